// File: rtl/smg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smg_scan_ctrl
// Purpose  : Time-multiplexed seven-segment scanner for N_DIGITS hex digits.
//            Provides a per-digit decimal point, per-digit blanking, leading-zero
//            suppression and 16-level PWM brightness. Inputs are captured into
//            shadow registers only at frame boundaries, so every frame is
//            internally consistent.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            data[4N-1:0]       - hex nibbles, digit 0 is the rightmost
//            dp[N-1:0]          - decimal point per digit (1 = lit)
//            blank[N-1:0]       - 1 = digit completely dark
//            lz_en              - 1 = suppress leading zeros
//            bright[3:0]        - lit for (bright+1)/16 of each digit slot
//            sm_wei[N-1:0]      - digit enables (registered)
//            sm_duan[7:0]       - segments {dp,g,f,e,d,c,b,a} (registered)
//            frame_done         - one-cycle pulse after the last digit slot
// Revision : 1.0 - initial release
// ============================================================================
module smg_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int SUB_DIV     = 6250,
    parameter int WEI_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [N_DIGITS-1:0]     sm_wei,
    output logic [7:0]              sm_duan,
    output logic                    frame_done
);

    localparam int c_SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int c_IDX_W = $clog2(N_DIGITS);

    localparam logic [c_SUB_W-1:0]  c_SUB_LAST = c_SUB_W'(SUB_DIV - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(N_DIGITS - 1);

    // XOR masks that turn the internal polarity (enables active-high,
    // segments active-low) into the board polarity.
    localparam logic [N_DIGITS-1:0] c_WEI_INV  = (WEI_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [7:0]          c_SEG_INV  = (SEG_ACT_LOW != 0) ? 8'h00 : 8'hFF;
    localparam logic [7:0]          c_SEG_OFF  = 8'hFF ^ c_SEG_INV;
    localparam logic [N_DIGITS-1:0] c_ONE      = {{(N_DIGITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------------
    logic [c_SUB_W-1:0]   r_sub_cnt;
    logic [3:0]           r_phase;
    logic [c_IDX_W-1:0]   r_idx;

    // Shadow copies of the inputs, decoded for the whole current frame
    logic [4*N_DIGITS-1:0] r_data_s;
    logic [N_DIGITS-1:0]   r_dp_s;
    logic [N_DIGITS-1:0]   r_blank_s;
    logic                  r_lz_en_s;
    logic [3:0]            r_bright_s;

    logic [N_DIGITS-1:0]   r_wei;
    logic [7:0]            r_duan;
    logic                  r_frame_done;

    logic                  w_sub_wrap;
    logic                  w_slot_end;
    logic                  w_frame_end;

    assign w_sub_wrap  = (r_sub_cnt == c_SUB_LAST);
    assign w_slot_end  = w_sub_wrap && (r_phase == 4'hF);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub_cnt <= '0;
            r_phase   <= '0;
            r_idx     <= '0;
        end else begin
            if (w_sub_wrap) begin
                r_sub_cnt <= '0;
                r_phase   <= r_phase + 4'd1;
            end else begin
                r_sub_cnt <= r_sub_cnt + c_SUB_W'(1);
            end
            if (w_slot_end) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    // Reset has priority, so a frame boundary coinciding with reset loads nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_s   <= '0;
            r_dp_s     <= '0;
            r_blank_s  <= '0;
            r_lz_en_s  <= 1'b0;
            r_bright_s <= '0;
        end else if (w_frame_end) begin
            r_data_s   <= data;
            r_dp_s     <= dp;
            r_blank_s  <= blank;
            r_lz_en_s  <= lz_en;
            r_bright_s <= bright;
        end
    end

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    function automatic logic [7:0] font(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // w_lead_zero[i]: nibbles N_DIGITS-1 down to i are all zero.
    logic [N_DIGITS-1:0] w_lead_zero;
    logic [N_DIGITS-1:0] w_suppress;

    always_comb begin
        w_lead_zero = '0;
        w_lead_zero[N_DIGITS-1] = (r_data_s[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            w_lead_zero[i] = w_lead_zero[i+1] && (r_data_s[4*i +: 4] == 4'h0);
        end
        w_suppress    = w_lead_zero & {N_DIGITS{r_lz_en_s}};
        w_suppress[0] = 1'b0;  // the units digit always shows something
    end

    logic [3:0]          w_nib;
    logic [7:0]          w_seg_low;
    logic                w_dark;
    logic                w_on;
    logic [N_DIGITS-1:0] w_wei_next;
    logic [7:0]          w_duan_next;

    always_comb begin
        w_nib     = r_data_s[4*r_idx +: 4];
        // A suppressed digit keeps its decimal point.
        w_seg_low = w_suppress[r_idx] ? 8'hFF : font(w_nib);
        if (r_dp_s[r_idx]) begin
            w_seg_low[7] = 1'b0;
        end
        w_dark      = w_suppress[r_idx] && !r_dp_s[r_idx];
        w_on        = (r_phase <= r_bright_s) && !r_blank_s[r_idx] && !w_dark;
        w_wei_next  = (w_on ? (c_ONE << r_idx) : {N_DIGITS{1'b0}}) ^ c_WEI_INV;
        w_duan_next = w_on ? (w_seg_low ^ c_SEG_INV) : c_SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wei        <= c_WEI_INV;
            r_duan       <= c_SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_wei        <= w_wei_next;
            r_duan       <= w_duan_next;
            r_frame_done <= w_frame_end;
        end
    end

    assign sm_wei     = r_wei;
    assign sm_duan    = r_duan;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
